keyexp_sched: RTL and testbench
===============================

# keyexp_sched

Round-key scheduler that sequences `top_keyexp` through AES-128 rounds 1..10 and stores all 11 round keys. It is loaded with one cipher key, issues one `start_in` pulse per round, and captures each `key_out` on the `ready_out` rising edge. It then serves any stored round key to the cipher core through a registered read port. It sits between the key-load interface and the round datapath, and owns the only instance of `top_keyexp`.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in WAIT per round before the scheduler flags an error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_in` in 128: cipher key. Uses the same byte layout as the `top_keyexp` `key_in` port, and is passed through unchanged.
- `key_load` in 1: one-cycle pulse that loads `key_in` and starts the expansion. Accepted in every state.
- `rk_rd_addr` in 4: round-key index, 0..10.
- `rk_rd_data` out 128: registered round key for the index on `rk_rd_addr`.
- `keys_valid` out 1: all 11 keys are stored and consistent with the last load.
- `busy` out 1: expansion in progress.
- `err` out 1: `top_keyexp` timed out.
- `ke_key_out` out 128: drives `top_keyexp.key_in`. Carries the previous round key.
- `ke_start_out` out 1: drives `top_keyexp.start_in`.
- `ke_round_out` out 4: drives `top_keyexp.round_in`.
- `ke_en_de_out` out 1: drives `top_keyexp.en_de`. Held at 1; forward expansion only.
- `ke_key_in` in 128: from `top_keyexp.key_out`.
- `ke_ready_in` in 1: from `top_keyexp.ready_out`.

## Operation
- Storage is `rk[0..10]`, 11×128 flops.
- `round` is a 4-bit counter covering 1..10.
- `rdy_q` holds the previous-cycle sample of `ke_ready_in`.
- FSM states:
  - IDLE: waits for `key_load`.
  - ISSUE: pulses start for the current round. Always exactly 1 cycle, then goes to WAIT.
  - WAIT: waits for the ready rising edge.
  - DONE: keys available.
  - ERR: timeout, latched.
- Key load, any state: `rk[0]` ← `key_in`, `round` ← 1, `keys_valid` ← 0, `err` ← 0, next state ISSUE. This aborts an in-flight expansion; a late `ke_ready_in` edge from the aborted round is ignored.
- ISSUE cycle outputs:
  - `ke_start_out` = 1.
  - `ke_round_out` = `round`.
  - `ke_key_out` = `rk[round-1]`.
- Outside ISSUE: `ke_start_out` = 0, and `ke_key_out`/`ke_round_out` hold their last values.
- WAIT:
  - Accept when `ke_ready_in`=1 and `rdy_q`=0. A level-high ready carried over from the previous round is never accepted.
  - On accept: `rk[round]` ← `ke_key_in`. If `round`=10, go to DONE. Otherwise `round` ← `round`+1 and go to ISSUE.
- Timeout:
  - The cycle counter clears on entry to WAIT.
  - If it reaches `TIMEOUT` without an accept, go to ERR with `err`=1.
  - ERR exits only via `key_load`.
- Flag decode:
  - `busy` = state ∈ {ISSUE, WAIT}.
  - `keys_valid` = state is DONE.
- Read port:
  - `rk_rd_data` ← `rk[rk_rd_addr]` on every clock edge, independent of FSM state.
  - An address of 11..15 returns 0.
  - Consumers may rely on the data only while `keys_valid`=1.
- Reset values:
  - State IDLE, `round`=1, `rdy_q`=0, counter 0.
  - All `rk` entries = 0.
  - `rk_rd_data`=0, `keys_valid`=0, `busy`=0, `err`=0.
  - `ke_start_out`=0, `ke_round_out`=0, `ke_key_out`=0, `ke_en_de_out`=1.
- Reset asserted mid-expansion: everything returns to its reset value immediately (asynchronous), and no partial key is retained as valid.

## Timing
- `key_load` is sampled at edge E0. The FSM is in ISSUE during cycle E0..E1.
- Each round costs 1 ISSUE cycle plus L WAIT cycles, where L (≥1) is the number of cycles from the start pulse to the ready rising edge.
- With a `top_keyexp` of constant L, `keys_valid` rises 10·(1+L) cycles after E0.
- `rk_rd_data` latency is 1 cycle from `rk_rd_addr`.
- `key_load` arriving in the same cycle as an accept wins. The key is not stored and the FSM goes to ISSUE for round 1.
- The timeout fires when the counter reaches `TIMEOUT`. `err` rises on the following edge.

## Test plan
- Bench drives `key_in` = 2b28ab09_7eaef7cf_15d2154f_16a6883c, one `key_load` pulse, real `top_keyexp` attached. Required response:
  - `keys_valid` rises and `busy` falls.
  - `rk[1]` = a088232a_fa54a36c_fe2c3976_17b13905.
  - `rk[10]` = d0c9e1b6_14ee3f63_f9250c0c_a889c8a6.
  - `rk[0]` equals `key_in`.
- Bench uses a stub with fixed L=3. Required response:
  - Exactly 10 `ke_start_out` pulses, each 1 cycle wide.
  - `ke_round_out` = 1..10 in order.
  - `keys_valid` rises exactly 40 cycles after E0.
- Bench uses a stub whose ready stays high between rounds and drops 1 cycle after start. Required response: no round is skipped, and each stored key equals the stub output for that round.
- Bench issues a second `key_load` (new key) while in WAIT at round 5. Required response:
  - `keys_valid` stays 0 until the full re-expansion completes.
  - Final `rk[1..10]` match the new key only.
- Bench uses a stub that never asserts ready, with `TIMEOUT`=8. Required response:
  - `err`=1 after the first round's timeout, and `busy`=0.
  - A subsequent `key_load` clears `err` and completes normally.
- Bench asserts `rst_n` mid-round 3, then reads addresses 0..15. Required response:
  - All outputs return to their reset values asynchronously.
  - `rk_rd_data`=0 for all addresses, with 1-cycle read latency.

Source files
------------

// File: rtl/keyexp_sched.sv
// keyexp_sched: sequences top_keyexp through AES-128 rounds 1..10, stores the
// cipher key plus the ten expanded round keys, and serves any of the eleven
// through a registered read port.
module keyexp_sched #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data,
    output logic         keys_valid,
    output logic         busy,
    output logic         err,
    output logic [127:0] ke_key_out,
    output logic         ke_start_out,
    output logic [3:0]   ke_round_out,
    output logic         ke_en_de_out,
    input  logic [127:0] ke_key_in,
    input  logic         ke_ready_in
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic           rdy_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   rk_q [0:10];
    logic [127:0]   rk_d [0:10];
    logic [127:0]   rd_data_q, rd_data_d;
    logic [127:0]   ke_key_q, ke_key_d;
    logic [3:0]     ke_round_q, ke_round_d;
    logic           accept;

    // State register and all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            round_q    <= 4'd1;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
            rd_data_q  <= '0;
            ke_key_q   <= '0;
            ke_round_q <= '0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            rdy_q      <= ke_ready_in;
            cnt_q      <= cnt_d;
            for (int unsigned i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
            rd_data_q  <= rd_data_d;
            ke_key_q   <= ke_key_d;
            ke_round_q <= ke_round_d;
        end
    end

    // Next-state: key load overrides everything; WAIT accepts only a ready rising edge
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        cnt_d      = cnt_q;
        rk_d       = rk_q;
        ke_key_d   = ke_key_q;
        ke_round_d = ke_round_q;
        accept     = (state_q == S_WAIT) && ke_ready_in && !rdy_q;

        if (key_load) begin
            rk_d[0]    = key_in;
            round_d    = 4'd1;
            state_d    = S_ISSUE;
            ke_key_d   = key_in;
            ke_round_d = 4'd1;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
                S_WAIT: begin
                    if (accept) begin
                        for (int unsigned i = 1; i < 11; i++) begin
                            if (round_q == 4'(i)) rk_d[i] = ke_key_in;
                        end
                        if (round_q == 4'd10) begin
                            state_d = S_DONE;
                        end else begin
                            // ke_key_out for the next round is the key being stored now
                            round_d    = round_q + 4'd1;
                            state_d    = S_ISSUE;
                            ke_key_d   = ke_key_in;
                            ke_round_d = round_q + 4'd1;
                        end
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read port: addresses past 10 read as zero
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < 11; i++) begin
            if (rk_rd_addr == 4'(i)) rd_data_d = rk_q[i];
        end
    end

    // Output decode from state and registered key-expander drive
    always_comb begin
        ke_start_out = (state_q == S_ISSUE);
        busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
        keys_valid   = (state_q == S_DONE);
        err          = (state_q == S_ERR);
        ke_en_de_out = 1'b1;
        ke_key_out   = ke_key_q;
        ke_round_out = ke_round_q;
        rk_rd_data   = rd_data_q;
    end

endmodule

// File: tb/tb_keyexp_sched.sv
// tb_keyexp_sched: directed bench for keyexp_sched with a behavioural
// top_keyexp stand-in (AES-128 forward key step, configurable latency and
// ready behaviour) and an AES key-expansion reference model.
module tb_keyexp_sched;

    localparam int unsigned TO = 8;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:79] RCON = 80'h01020408102040801b36;

    localparam logic [127:0] FIPS_KEY = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
    localparam logic [127:0] FIPS_RK1 = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
    localparam logic [127:0] FIPS_RK10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic [3:0]   rk_rd_addr = '0;
    logic [127:0] rk_rd_data;
    logic         keys_valid;
    logic         busy;
    logic         err;
    logic [127:0] ke_key_out;
    logic         ke_start_out;
    logic [3:0]   ke_round_out;
    logic         ke_en_de_out;
    logic [127:0] ke_key_in = '0;
    logic         ke_ready_in = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model: expected contents of rk[0..10] for the last load
    logic [127:0] exp_rk [0:10];

    // stand-in key expander controls: mode 0 normal, 1 sticky ready, 2 never ready
    int st_mode = 0;
    int st_lat = 3;
    int st_cnt = 0;
    bit st_drop = 1'b0;
    logic [127:0] st_key = '0;
    int st_rnd = 1;

    bit mon_en = 1'b0;
    int next_rnd = 1;
    int start_cnt = 0;

    logic [3:0] addr_prev = '0;
    logic       kv_prev = 1'b0;

    keyexp_sched #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_load    (key_load),
        .rk_rd_addr  (rk_rd_addr),
        .rk_rd_data  (rk_rd_data),
        .keys_valid  (keys_valid),
        .busy        (busy),
        .err         (err),
        .ke_key_out  (ke_key_out),
        .ke_start_out(ke_start_out),
        .ke_round_out(ke_round_out),
        .ke_en_de_out(ke_en_de_out),
        .ke_key_in   (ke_key_in),
        .ke_ready_in (ke_ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*int'(x) +: 8];
    endfunction

    // One AES-128 key-schedule step; key bytes laid out row-major (row 0 in the top word)
    function automatic logic [127:0] ks_next(input logic [127:0] k, input int rnd);
        logic [7:0] m [4][4];
        logic [7:0] t [4];
        logic [127:0] r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = k[127-32*i-8*j -: 8];
        for (int i = 0; i < 4; i++) t[i] = sbox(m[(i+1)%4][3]);
        t[0] = t[0] ^ RCON[8*(rnd-1) +: 8];
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) begin
                if (j == 0) m[i][j] = m[i][j] ^ t[i];
                else        m[i][j] = m[i][j] ^ m[i][j-1];
            end
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[127-32*i-8*j -: 8] = m[i][j];
        return r;
    endfunction

    function automatic logic [127:0] exp_at(input int a);
        if (a >= 0 && a <= 10) return exp_rk[a];
        return '0;
    endfunction

    task automatic set_model(input logic [127:0] k);
        exp_rk[0] = k;
        for (int i = 1; i <= 10; i++) exp_rk[i] = ks_next(exp_rk[i-1], i);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Stand-in top_keyexp: ready rises st_lat cycles after the start pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            ke_ready_in = 1'b0;
            st_cnt = 0;
            st_drop = 1'b0;
        end else if (ke_start_out) begin
            st_key = ke_key_out;
            st_rnd = int'(ke_round_out);
            st_cnt = st_lat;
            if (st_mode != 1) ke_ready_in = 1'b0;
            st_drop = (st_mode == 1);
        end else begin
            if (st_drop) begin
                ke_ready_in = 1'b0;
                st_drop = 1'b0;
            end
            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0 && st_mode != 2) begin
                    ke_ready_in = 1'b1;
                    ke_key_in = ks_next(st_key, st_rnd);
                end
            end
        end
    end

    always @(posedge clk) begin
        addr_prev = rk_rd_addr;
        kv_prev = keys_valid;
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        int r;
        if (rst_n) begin
            chk("en_de_high", {127'b0, ke_en_de_out}, 128'd1);
            chk("flags_exclusive", 128'(int'(busy) + int'(keys_valid) + int'(err) <= 1), 128'd1);
            if (keys_valid && kv_prev)
                chk("rd_data", rk_rd_data, exp_at(int'(addr_prev)));
            if (ke_start_out) begin
                r = int'(ke_round_out);
                if (r >= 1 && r <= 10) chk("issue_key", ke_key_out, exp_at(r - 1));
                else chk("issue_round_range", {124'b0, ke_round_out}, 128'd1);
            end
        end
    end

    // Start-pulse order monitor
    always @(negedge clk) begin
        if (!mon_en) begin
            next_rnd = 1;
            start_cnt = 0;
        end else if (rst_n && ke_start_out) begin
            chk("start_round_order", {124'b0, ke_round_out}, 128'(next_rnd));
            next_rnd++;
            start_cnt++;
        end
    end

    task automatic load_key(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        key_load = 1'b1;
        set_model(k);
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!keys_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_wait_round(input int rnd, input string nm);
        int n = 0;
        while (!(busy && !ke_start_out && int'(ke_round_out) == rnd) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {124'b0, ke_round_out}, 128'(rnd));
    endtask

    task automatic read_chk(input int a, input logic [127:0] req, input string nm);
        @(negedge clk);
        rk_rd_addr = 4'(a);
        @(negedge clk);
        chk(nm, rk_rd_data, req);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rk_rd_addr = 4'(a);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, rk_rd_data, '0);
        chk({tag, "_keys_valid"}, {127'b0, keys_valid}, '0);
        chk({tag, "_busy"}, {127'b0, busy}, '0);
        chk({tag, "_err"}, {127'b0, err}, '0);
        chk({tag, "_start"}, {127'b0, ke_start_out}, '0);
        chk({tag, "_round"}, {124'b0, ke_round_out}, '0);
        chk({tag, "_ke_key"}, ke_key_out, '0);
        chk({tag, "_en_de"}, {127'b0, ke_en_de_out}, 128'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // FIPS-197 key through the AES stand-in, L=2
        st_mode = 0;
        st_lat = 2;
        load_key(FIPS_KEY);
        chk("t1_busy_after_load", {127'b0, busy}, 128'd1);
        wait_valid(200, n);
        chk("t1_valid_latency", 128'(n), 128'd30);
        chk("t1_busy_low", {127'b0, busy}, '0);
        chk("model_rk1", exp_rk[1], FIPS_RK1);
        chk("model_rk10", exp_rk[10], FIPS_RK10);
        read_chk(1, FIPS_RK1, "t1_rk1");
        read_chk(10, FIPS_RK10, "t1_rk10");
        read_chk(0, FIPS_KEY, "t1_rk0");
        read_chk(13, '0, "t1_addr13");
        sweep();

        // fixed L=3: ten single-cycle starts in order, 40-cycle expansion
        st_lat = 3;
        mon_en = 1'b1;
        load_key(128'h00010203_04050607_08090a0b_0c0d0e0f);
        wait_valid(200, n);
        mon_en = 1'b0;
        chk("t2_valid_latency", 128'(n), 128'd40);
        chk("t2_start_count", 128'(start_cnt), 128'd10);
        sweep();

        // ready held high across rounds, dropping one cycle after start
        st_mode = 1;
        load_key(128'hdeadbeef_01234567_89abcdef_cafef00d);
        wait_valid(200, n);
        chk("t3_valid_latency", 128'(n), 128'd40);
        sweep();

        // reload while waiting on round 5
        st_mode = 0;
        load_key(128'h11111111_22222222_33333333_44444444);
        wait_wait_round(5, "t4_reach_round5");
        chk("t4_valid_before_reload", {127'b0, keys_valid}, '0);
        load_key(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
        wait_valid(200, n);
        chk("t4_valid_latency", 128'(n), 128'd40);
        sweep();

        // ready never arrives: timeout, then recovery by a fresh load
        st_mode = 2;
        load_key(128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa);
        n = 0;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t5_err_latency", 128'(n), 128'(TO + 2));
        chk("t5_busy_low", {127'b0, busy}, '0);
        chk("t5_valid_low", {127'b0, keys_valid}, '0);
        repeat (3) @(negedge clk);
        chk("t5_err_latched", {127'b0, err}, 128'd1);
        st_mode = 0;
        load_key(128'h01020304_05060708_090a0b0c_0d0e0f10);
        chk("t5_err_cleared", {127'b0, err}, '0);
        chk("t5_busy_again", {127'b0, busy}, 128'd1);
        wait_valid(200, n);
        chk("t5_valid_latency", 128'(n), 128'd40);
        sweep();

        // asynchronous reset in the middle of round 3
        load_key(128'h76543210_fedcba98_13579bdf_2468ace0);
        wait_wait_round(3, "t6_reach_round3");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rk_rd_addr = 4'(a);
            @(negedge clk);
            chk("t6_rd_zero", rk_rd_data, '0);
        end
        chk("t6_valid_low", {127'b0, keys_valid}, '0);
        chk("t6_busy_low", {127'b0, busy}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
